bsg_dmc_dq_turnaround_seq: RTL and testbench

Sequences the bidirectional LPDDR DQ/DQS pad output enables in the chip padring for each write or read burst. It accepts one command at a time from the DRAM controller and waits out the programmed write or read latency. For writes it drives the DQS preamble, DQ burst and postamble and pulls write data; for reads it gates read capture. It then enforces a bus turnaround gap before accepting the next command.

---
 rtl/bsg_dmc_dq_turnaround_seq_pkg.sv | 44 ++++
 rtl/bsg_dmc_dq_turnaround_seq_if.sv | 33 +++
 rtl/bsg_dmc_dq_turnaround_seq_counter.sv | 34 +++
 rtl/bsg_dmc_dq_turnaround_seq.sv | 211 +++++++++++++++++++++
 tb/tb_bsg_dmc_dq_turnaround_seq.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/bsg_dmc_dq_turnaround_seq_pkg.sv
// Shared types and helpers for the LPDDR DQ/DQS turnaround sequencer.
//   bsg_dmc_seq_state_e : FSM state encoding (one code per burst phase)
//   min_lat_lp          : smallest latency the sequencer can honour
//   burst_cycles_f      : DDR beats per burst -> core cycles per burst
//   cnt_width_f         : width of the shared phase down-counter
package bsg_dmc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_WL   = 3'd1,
    PREAMBLE  = 3'd2,
    WR_BURST  = 3'd3,
    POSTAMBLE = 3'd4,
    WAIT_RL   = 3'd5,
    RD_BURST  = 3'd6,
    TURN      = 3'd7
  } bsg_dmc_seq_state_e;

  // Latencies below this are rounded up: a write needs at least one cycle
  // of DQS preamble between accept and the first data beat.
  localparam int min_lat_lp = 2;

  // Two DDR beats per core clock.
  function automatic int burst_cycles_f(input int burst_len);
    return burst_len / 2;
  endfunction

  function automatic int max3_f(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    else m = m;
    if (c > m) m = c;
    else m = m;
    return m;
  endfunction

  // One spare bit of headroom so eff-2/eff-3 never wraps for any legal field value.
  function automatic int cnt_width_f(input int lat_width, input int burst_len,
                                     input int turnaround);
    return max3_f(lat_width, $clog2(burst_cycles_f(burst_len)), $clog2(turnaround)) + 1;
  endfunction

endpackage

// File: rtl/bsg_dmc_dq_turnaround_seq_if.sv
// Command and pad-control bundle between the DRAM controller/padring and the
// DQ/DQS turnaround sequencer.
//   master : controller side, drives cmd_v_i/cmd_we_i/wl_i/rl_i
//   slave  : sequencer side, drives cmd_ready_o, pad output enables,
//            write-data yumi, read capture window and busy
interface bsg_dmc_dq_turnaround_seq_if #(
  parameter int dq_width_p  = 32,
  parameter int dqs_width_p = 4,
  parameter int lat_width_p = 4
) ();

  logic                   cmd_v_i;
  logic                   cmd_we_i;
  logic                   cmd_ready_o;
  logic [lat_width_p-1:0] wl_i;
  logic [lat_width_p-1:0] rl_i;
  logic [dq_width_p-1:0]  dq_oen_o;
  logic [dqs_width_p-1:0] dqs_oen_o;
  logic                   wr_data_yumi_o;
  logic                   rd_capture_en_o;
  logic                   busy_o;

  modport master (
    output cmd_v_i, cmd_we_i, wl_i, rl_i,
    input  cmd_ready_o, dq_oen_o, dqs_oen_o, wr_data_yumi_o, rd_capture_en_o, busy_o
  );

  modport slave (
    input  cmd_v_i, cmd_we_i, wl_i, rl_i,
    output cmd_ready_o, dq_oen_o, dqs_oen_o, wr_data_yumi_o, rd_capture_en_o, busy_o
  );

endinterface

// File: rtl/bsg_dmc_dq_turnaround_seq_counter.sv
// Loadable saturating down-counter shared by all timed phases of the
// sequencer.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   load_i           : load load_val_i this cycle (has priority)
//   load_val_i       : count to start the phase from
//   zero_o           : count is 0 (phase ends this cycle)
module bsg_dmc_seq_counter #(
  parameter int width_p = 5
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  output logic               zero_o
);

  logic [width_p-1:0] cnt_r;

  // Load on phase entry, otherwise count down and hold at zero.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_r <= {width_p{1'b0}};
    end else if (load_i) begin
      cnt_r <= load_val_i;
    end else if (cnt_r != {width_p{1'b0}}) begin
      cnt_r <= cnt_r - width_p'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero_o = (cnt_r == {width_p{1'b0}});

endmodule

// File: rtl/bsg_dmc_dq_turnaround_seq.sv
// LPDDR DQ/DQS pad output-enable sequencer. Accepts one write or read
// command at a time, waits out the latched latency, then drives the DQS
// preamble / DQ burst / DQS postamble (writes, pulling one data word per
// burst cycle) or opens the read capture window (reads), and finally holds
// the bus idle for turnaround_p cycles before the next command.
//   clk_i, reset_n_i : clock, asynchronous active-low reset (deassertion
//                      is synchronised outside this block)
//   bus (slave)      : cmd_v_i/cmd_we_i/cmd_ready_o handshake, wl_i/rl_i
//                      latencies, dq_oen_o/dqs_oen_o (active-low),
//                      wr_data_yumi_o, rd_capture_en_o, busy_o
// Every output is a flop, so reset forces the pads to tristate immediately.
module bsg_dmc_dq_turnaround_seq
  import bsg_dmc_seq_pkg::*;
#(
  parameter int dq_width_p   = 32,
  parameter int dqs_width_p  = 4,
  parameter int burst_len_p  = 8,
  parameter int lat_width_p  = 4,
  parameter int turnaround_p = 2
) (
  input  logic clk_i,
  input  logic reset_n_i,
  bsg_dmc_dq_turnaround_seq_if.slave bus
);

  localparam int bc_lp        = burst_cycles_f(burst_len_p);
  localparam int cnt_width_lp = cnt_width_f(lat_width_p, burst_len_p, turnaround_p);
  localparam int lane_width_lp = dq_width_p / dqs_width_p;

  // A phase lasting N cycles loads N-1; the FSM leaves when the count is 0.
  localparam logic [cnt_width_lp-1:0] one_cycle_lp   = cnt_width_lp'(0);
  localparam logic [cnt_width_lp-1:0] burst_load_lp  = cnt_width_lp'(bc_lp - 1);
  localparam logic [cnt_width_lp-1:0] turn_load_lp   = cnt_width_lp'(turnaround_p - 1);
  localparam logic [cnt_width_lp-1:0] min_lat_cnt_lp = cnt_width_lp'(min_lat_lp);

  bsg_dmc_seq_state_e state_r;
  bsg_dmc_seq_state_e state_n_s;

  logic [cnt_width_lp-1:0] wl_eff_s;
  logic [cnt_width_lp-1:0] rl_eff_s;
  logic                    load_s;
  logic [cnt_width_lp-1:0] load_val_s;
  logic                    cnt_zero_s;

  logic dqs_drive_n_s;
  logic dq_drive_n_s;
  logic capture_n_s;
  logic idle_n_s;

  logic [dqs_width_p-1:0] dqs_lane_oen_r;
  logic [dqs_width_p-1:0] dq_lane_oen_r;
  logic                   yumi_r;
  logic                   capture_r;
  logic                   ready_r;
  logic                   busy_r;

  // Effective latency: 0 and 1 are stretched to the minimum.
  always_comb begin
    wl_eff_s = cnt_width_lp'(bus.wl_i);
    rl_eff_s = cnt_width_lp'(bus.rl_i);
    if (wl_eff_s < min_lat_cnt_lp) wl_eff_s = min_lat_cnt_lp;
    else wl_eff_s = wl_eff_s;
    if (rl_eff_s < min_lat_cnt_lp) rl_eff_s = min_lat_cnt_lp;
    else rl_eff_s = rl_eff_s;
  end

  bsg_dmc_seq_counter #(
    .width_p(cnt_width_lp)
  ) phase_cnt (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .load_i     (load_s),
    .load_val_i (load_val_s),
    .zero_o     (cnt_zero_s)
  );

  // Next-state and counter-load decode.
  always_comb begin
    state_n_s  = state_r;
    load_s     = 1'b0;
    load_val_s = one_cycle_lp;
    case (state_r)
      IDLE: begin
        if (bus.cmd_v_i) begin
          load_s = 1'b1;
          if (bus.cmd_we_i) begin
            // WAIT_WL spans eff-2 cycles, which is none at the minimum latency.
            if (wl_eff_s == min_lat_cnt_lp) begin
              state_n_s  = PREAMBLE;
              load_val_s = one_cycle_lp;
            end else begin
              state_n_s  = WAIT_WL;
              load_val_s = wl_eff_s - cnt_width_lp'(3);
            end
          end else begin
            state_n_s  = WAIT_RL;
            load_val_s = rl_eff_s - cnt_width_lp'(2);
          end
        end else begin
          state_n_s = IDLE;
        end
      end
      WAIT_WL: begin
        if (cnt_zero_s) begin
          state_n_s  = PREAMBLE;
          load_s     = 1'b1;
          load_val_s = one_cycle_lp;
        end else begin
          state_n_s = WAIT_WL;
        end
      end
      PREAMBLE: begin
        if (cnt_zero_s) begin
          state_n_s  = WR_BURST;
          load_s     = 1'b1;
          load_val_s = burst_load_lp;
        end else begin
          state_n_s = PREAMBLE;
        end
      end
      WR_BURST: begin
        if (cnt_zero_s) begin
          state_n_s  = POSTAMBLE;
          load_s     = 1'b1;
          load_val_s = one_cycle_lp;
        end else begin
          state_n_s = WR_BURST;
        end
      end
      POSTAMBLE: begin
        if (cnt_zero_s) begin
          state_n_s  = TURN;
          load_s     = 1'b1;
          load_val_s = turn_load_lp;
        end else begin
          state_n_s = POSTAMBLE;
        end
      end
      WAIT_RL: begin
        if (cnt_zero_s) begin
          state_n_s  = RD_BURST;
          load_s     = 1'b1;
          load_val_s = burst_load_lp;
        end else begin
          state_n_s = WAIT_RL;
        end
      end
      RD_BURST: begin
        if (cnt_zero_s) begin
          state_n_s  = TURN;
          load_s     = 1'b1;
          load_val_s = turn_load_lp;
        end else begin
          state_n_s = RD_BURST;
        end
      end
      TURN: begin
        if (cnt_zero_s) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = TURN;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // Output decode of the next state so the registered outputs line up with state_r.
  always_comb begin
    dqs_drive_n_s = (state_n_s == PREAMBLE) || (state_n_s == WR_BURST) ||
                    (state_n_s == POSTAMBLE);
    dq_drive_n_s  = (state_n_s == WR_BURST);
    capture_n_s   = (state_n_s == RD_BURST);
    idle_n_s      = (state_n_s == IDLE);
  end

  // FSM state plus one registered output flop per lane / control bit.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r        <= IDLE;
      dqs_lane_oen_r <= {dqs_width_p{1'b1}};
      dq_lane_oen_r  <= {dqs_width_p{1'b1}};
      yumi_r         <= 1'b0;
      capture_r      <= 1'b0;
      ready_r        <= 1'b1;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_n_s;
      dqs_lane_oen_r <= {dqs_width_p{~dqs_drive_n_s}};
      dq_lane_oen_r  <= {dqs_width_p{~dq_drive_n_s}};
      yumi_r         <= dq_drive_n_s;
      capture_r      <= capture_n_s;
      ready_r        <= idle_n_s;
      busy_r         <= ~idle_n_s;
    end
  end

  // Fan each lane's DQ enable flop out to its pads.
  for (genvar l = 0; l < dqs_width_p; l++) begin : g_lane
    assign bus.dq_oen_o[l*lane_width_lp +: lane_width_lp] = {lane_width_lp{dq_lane_oen_r[l]}};
  end

  assign bus.dqs_oen_o       = dqs_lane_oen_r;
  assign bus.wr_data_yumi_o  = yumi_r;
  assign bus.rd_capture_en_o = capture_r;
  assign bus.cmd_ready_o     = ready_r;
  assign bus.busy_o          = busy_r;

endmodule

// File: tb/tb_bsg_dmc_dq_turnaround_seq.sv
// Self-checking bench for bsg_dmc_dq_turnaround_seq. A timing model pushes
// the expected per-cycle output vector for each accepted command into a
// queue; each test pops and compares one entry per clock on the falling edge.
module tb_bsg_dmc_dq_turnaround_seq;
  localparam int DQ  = 32;
  localparam int DQS = 4;
  localparam int BL  = 8;
  localparam int LW  = 4;
  localparam int TA  = 2;
  localparam int BC  = BL / 2;
  localparam int EW  = 4 + DQ + DQS;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [EW-1:0] exp_q[$];

  bsg_dmc_dq_turnaround_seq_if #(.dq_width_p(DQ), .dqs_width_p(DQS), .lat_width_p(LW)) ifc ();

  bsg_dmc_dq_turnaround_seq #(
    .dq_width_p(DQ), .dqs_width_p(DQS), .burst_len_p(BL),
    .lat_width_p(LW), .turnaround_p(TA)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] mk(input logic rdy, input logic bsy, input logic ym,
                                       input logic cp, input logic dq_drv, input logic dqs_drv);
    return {rdy, bsy, ym, cp, {DQ{~dq_drv}}, {DQS{~dqs_drv}}};
  endfunction

  function automatic logic [EW-1:0] obs();
    return {ifc.cmd_ready_o, ifc.busy_o, ifc.wr_data_yumi_o, ifc.rd_capture_en_o,
            ifc.dq_oen_o, ifc.dqs_oen_o};
  endfunction

  // Expected outputs for cycles T+1 .. first IDLE cycle after a command accepted at T.
  task automatic push_trace(input logic we, input int lat);
    int eff;
    eff = (lat < 2) ? 2 : lat;
    if (we) begin
      for (int k = 0; k < eff - 2; k++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      for (int k = 0; k < BC; k++) exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    end else begin
      for (int k = 0; k < eff - 1; k++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      for (int k = 0; k < BC; k++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    end
    for (int k = 0; k < TA; k++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic test_reset();
    logic [EW-1:0] e;
    logic [EW-1:0] o;
    rst_n = 1'b0;
    ifc.cmd_v_i = 1'b0; ifc.cmd_we_i = 1'b0; ifc.wl_i = 4'd0; ifc.rl_i = 4'd0;
    #12;
    e = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    o = obs();
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_held obs=%h exp=%h", o, e); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin errors++; $display("FAIL reset_idle obs=%h exp=%h", o, e); end
    end
  endtask

  // One command from idle; latency inputs are scrambled after accept.
  task automatic test_single(input logic we, input int lat, input string name);
    logic [EW-1:0] e;
    logic [EW-1:0] o;
    int yumi_cnt;
    int cap_cnt;
    yumi_cnt = 0; cap_cnt = 0;
    @(negedge clk);
    ifc.cmd_v_i = 1'b1; ifc.cmd_we_i = we;
    ifc.wl_i = LW'(lat); ifc.rl_i = LW'(lat);
    push_trace(we, lat);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      ifc.cmd_v_i = 1'b0;
      ifc.wl_i = LW'($urandom_range(0, 15));
      ifc.rl_i = LW'($urandom_range(0, 15));
      e = exp_q.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin errors++; $display("FAIL %s obs=%h exp=%h", name, o, e); end
      if (ifc.wr_data_yumi_o === 1'b1) yumi_cnt++;
      if (ifc.rd_capture_en_o === 1'b1) cap_cnt++;
    end
    checks++;
    if (yumi_cnt !== (we ? BC : 0)) begin
      errors++; $display("FAIL %s_yumi_count got=%0d exp=%0d", name, yumi_cnt, we ? BC : 0);
    end
    checks++;
    if (cap_cnt !== (we ? 0 : BC)) begin
      errors++; $display("FAIL %s_capture_count got=%0d exp=%0d", name, cap_cnt, we ? 0 : BC);
    end
  endtask

  // cmd_v held high with W, R, W; each accept lands on the IDLE cycle.
  task automatic test_back_to_back();
    logic [EW-1:0] e;
    logic [EW-1:0] o;
    logic we_seq [3];
    int idx;
    int yumi_cnt;
    we_seq[0] = 1'b1; we_seq[1] = 1'b0; we_seq[2] = 1'b1;
    idx = 0; yumi_cnt = 0;
    @(negedge clk);
    ifc.cmd_v_i = 1'b1; ifc.cmd_we_i = we_seq[0]; ifc.wl_i = 4'd3; ifc.rl_i = 4'd3;
    push_trace(we_seq[0], 3);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin errors++; $display("FAIL b2b_cmd%0d obs=%h exp=%h", idx, o, e); end
      checks++;
      if ((ifc.dq_oen_o !== {DQ{1'b1}}) && (ifc.rd_capture_en_o === 1'b1)) begin
        errors++; $display("FAIL b2b_overlap dq_oen=%h capture=%b exp=no overlap",
                           ifc.dq_oen_o, ifc.rd_capture_en_o);
      end
      if (ifc.wr_data_yumi_o === 1'b1) yumi_cnt++;
      if (e[EW-1] === 1'b1) begin
        checks++;
        if (yumi_cnt !== (we_seq[idx] ? BC : 0)) begin
          errors++; $display("FAIL b2b_yumi_cmd%0d got=%0d exp=%0d", idx, yumi_cnt,
                             we_seq[idx] ? BC : 0);
        end
        yumi_cnt = 0;
        idx++;
        if (idx < 3) begin
          ifc.cmd_we_i = we_seq[idx];
          push_trace(we_seq[idx], 3);
        end else begin
          ifc.cmd_v_i = 1'b0;
        end
      end
    end
  endtask

  // Reset pulled in burst cycle 2 of a write; pads must release before the next edge.
  task automatic test_reset_mid();
    logic [EW-1:0] e;
    logic [EW-1:0] o;
    @(negedge clk);
    ifc.cmd_v_i = 1'b1; ifc.cmd_we_i = 1'b1; ifc.wl_i = 4'd3;
    push_trace(1'b1, 3);
    // wl=3: wait at T+1, preamble T+2, burst cycles 1 and 2 at T+3, T+4
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ifc.cmd_v_i = 1'b0;
      e = exp_q.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin errors++; $display("FAIL rstmid_pre obs=%h exp=%h", o, e); end
    end
    #1 rst_n = 1'b0;
    #1;
    e = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    o = obs();
    checks++;
    if (o !== e) begin errors++; $display("FAIL rstmid_async obs=%h exp=%h", o, e); end
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = obs();
      checks++;
      if (o !== e) begin errors++; $display("FAIL rstmid_after obs=%h exp=%h", o, e); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single(1'b1, 4, "write_wl4");
    test_single(1'b0, 5, "read_rl5");
    test_single(1'b1, 0, "write_wl0");
    test_single(1'b1, 2, "write_wl2");
    test_single(1'b0, 1, "read_rl1");
    test_single(1'b1, 15, "write_wl15");
    test_back_to_back();
    test_reset_mid();
    test_single(1'b0, 3, "read_after_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
